// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the CORDIC arbiter: tag type, limits and
// the round-robin pick used by the grant logic.
package cordic_arb_pkg;

  localparam int NREQ_MAX         = 8;
  localparam int CORDIC_OCCUPANCY = 21;

  typedef logic [2:0] tag_t;

  // First requester after ptr (wrapping mod nreq) with req set; ptr when none.
  function automatic tag_t rr_next(input logic [NREQ_MAX-1:0] req,
                                   input tag_t                ptr,
                                   input int                  nreq);
    tag_t pick;
    int   idx;
    pick = ptr;
    for (int i = NREQ_MAX; i >= 1; i--) begin
      if (i <= nreq) begin
        idx = (int'(ptr) + i) % nreq;
        if (req[idx[2:0]]) pick = tag_t'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cordic_arbiter_tag_fifo.sv
// First-word-fall-through FIFO of requester tags, one entry per sample
// currently inside the CORDIC.
module tag_fifo
  import cordic_arb_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  tag_t        wdata,
  input  logic        pop,
  output tag_t        rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end for one shared vector CORDIC; results are steered
// back to their issuing requester using an in-order tag FIFO.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int TAG_DEPTH = 32,
  localparam int CW        = $clog2(TAG_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*NREQ-1:0]   t_x,
  input  logic [16*NREQ-1:0]   t_y,
  input  logic [NREQ-1:0]      t_valid,
  output logic [NREQ-1:0]      t_ready,
  output logic [15:0]          i_mag,
  output logic [15:0]          i_angle,
  output logic [NREQ-1:0]      i_valid,
  input  logic [NREQ-1:0]      i_ready,
  output logic [15:0]          c_x,
  output logic [15:0]          c_y,
  output logic                 c_valid,
  input  logic                 c_ready,
  input  logic [15:0]          c_mag,
  input  logic [15:0]          c_angle,
  input  logic                 c_rvalid,
  output logic                 c_rready,
  output logic [CW-1:0]        inflight,
  output logic                 err_orphan
);

  tag_t                rr_ptr;
  tag_t                grant;
  tag_t                head;
  logic                tag_full;
  logic                tag_empty;
  logic                any_req;
  logic                push;
  logic                pop;
  logic                dst_ready;
  logic [NREQ_MAX-1:0] req_ext;

  assign req_ext = NREQ_MAX'(t_valid);
  assign grant   = rr_next(req_ext, rr_ptr, NREQ);
  assign any_req = |t_valid;

  assign c_valid  = ~rst & any_req & ~tag_full;
  assign c_rready = ~rst & ~tag_empty & dst_ready;
  assign push     = c_valid & c_ready;
  assign pop      = c_rvalid & c_rready;
  assign i_mag    = c_mag;
  assign i_angle  = c_angle;

  always_comb begin
    c_x       = '0;
    c_y       = '0;
    t_ready   = '0;
    i_valid   = '0;
    dst_ready = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant == tag_t'(r)) begin
        c_x        = t_x[16*r +: 16];
        c_y        = t_y[16*r +: 16];
        t_ready[r] = c_valid & c_ready;
      end
      if (head == tag_t'(r)) begin
        dst_ready  = i_ready[r];
        i_valid[r] = ~rst & c_rvalid & ~tag_empty;
      end
    end
  end

  tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (grant),
    .pop   (pop),
    .rdata (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= tag_t'(NREQ - 1);
      err_orphan <= 1'b0;
    end else begin
      if (push) rr_ptr <= grant;
      // A result with no outstanding tag means the CORDIC and this block disagree.
      if (c_rvalid & tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule
